// File: rtl/data_sync_tx.sv
// data_sync_tx: source-domain launcher for a multi-flop bus synchronizer.
//
// Accepts a word on a valid/ready interface and drives it onto a held-stable bus.
// A level request (bus_enable_o) accompanies the bus. The block then runs a four-phase
// handshake against the destination acknowledge before it accepts the next word.
// The acknowledge is asynchronous and passes through an internal NUM_STAGES-flop
// synchronizer; only the synchronized copy is used.
//
// Optional feature: define DATA_SYNC_TX_TIMEOUT_EN to abort a handshake that stalls
// in REQ or REL. The abort fires when the stall counter reaches TIMEOUT_CYCLES-1 and
// raises a one-cycle tx_err_o pulse. Without the macro, tx_err_o is tied to 0 and the
// FSM waits indefinitely.
//
// Ports:
//   clk_i         source-domain clock, rising edge
//   rst_ni        asynchronous active-low reset
//   in_data_i     word to transfer
//   in_valid_i    in_data_i valid
//   in_ready_o    block can accept a word (IDLE)
//   unsync_bus_o  registered data toward destination synchronizer
//   bus_enable_o  registered level request toward destination
//   ack_async_i   destination acknowledge, asynchronous to clk_i
//   busy_o        transfer in progress
//   tx_done_o     one-cycle pulse, handshake completed
//   tx_err_o      one-cycle pulse, timeout abort
module data_sync_tx #(
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BUS_WIDTH-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [BUS_WIDTH-1:0] unsync_bus_o,
    output logic                 bus_enable_o,
    input  logic                 ack_async_i,
    output logic                 busy_o,
    output logic                 tx_done_o,
    output logic                 tx_err_o
);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("data_sync_tx: NUM_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("data_sync_tx: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

    state_e                 state_q;
    logic [BUS_WIDTH-1:0]   bus_q;
    logic                   en_q;
    logic                   done_q;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_sync;

    // Acknowledge synchronizer; bit 0 is the metastability-exposed flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ack_async_i};
        end
    end

    assign ack_sync = ack_sync_q[NUM_STAGES-1];

`ifdef DATA_SYNC_TX_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        bus_q   <= in_data_i;
                        en_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    // A real acknowledge takes priority over a coincident timeout.
                    if (ack_sync) begin
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRel;
                    end else if (cnt_q == CntMax) begin
                        en_q    <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRel: begin
                    if (!ack_sync) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_err_o = err_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        bus_q   <= in_data_i;
                        en_q    <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (ack_sync) begin
                        en_q    <= 1'b0;
                        state_q <= StRel;
                    end
                end
                StRel: begin
                    if (!ack_sync) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_err_o = 1'b0;
`endif

    assign in_ready_o   = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign unsync_bus_o = bus_q;
    assign bus_enable_o = en_q;
    assign tx_done_o    = done_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx. The bench plays the destination side.
// It drives the acknowledge on the falling edge, so every rise or fall of ack_async
// takes effect on the request exactly NS+1 rising edges later. The expected bus word
// is tracked from accepted transactions only.
module tb_data_sync_tx;

    localparam int unsigned NS = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          ack_async;
    logic          busy;
    logic          tx_done;
    logic          tx_err;

    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] exp_bus;

    data_sync_tx #(
        .NUM_STAGES    (NS),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .unsync_bus_o(unsync_bus),
        .bus_enable_o(bus_enable),
        .ack_async_i (ack_async),
        .busy_o      (busy),
        .tx_done_o   (tx_done),
        .tx_err_o    (tx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [BW-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        exp_bus = w;
        chk("acc_en", bus_enable, 1'b1);
        chk("acc_bus", unsync_bus, exp_bus);
        chk("acc_ready", in_ready, 1'b0);
        chk("acc_busy", busy, 1'b1);
        chk("acc_done_pulse_end", tx_done, 1'b0);
    endtask

    // Keep in_valid high with changing data through REQ/REL; it must be ignored.
    task automatic handshake(input int d_req, input int d_rel);
        in_data = BW'($urandom);
        repeat (d_req) begin
            step();
            chk("req_en", bus_enable, 1'b1);
            chk("req_bus", unsync_bus, exp_bus);
            chk("req_ready", in_ready, 1'b0);
            in_data = BW'($urandom);
        end
        ack_async = 1'b1;
        repeat (NS) step();
        chk("ack_pre_en", bus_enable, 1'b1);
        step();
        chk("ack_fall_en", bus_enable, 1'b0);
        chk("rel_busy", busy, 1'b1);
        chk("rel_bus", unsync_bus, exp_bus);
        chk("rel_err", tx_err, 1'b0);
        repeat (d_rel) begin
            step();
            chk("rel_en", bus_enable, 1'b0);
            chk("rel_hold_bus", unsync_bus, exp_bus);
            in_data = BW'($urandom);
        end
        ack_async = 1'b0;
        repeat (NS) step();
        chk("done_early", tx_done, 1'b0);
        step();
        chk("done_pulse", tx_done, 1'b1);
        chk("done_ready", in_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_bus", unsync_bus, exp_bus);
        chk("done_err", tx_err, 1'b0);
        in_valid = 1'b0;
        in_data  = BW'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = BW'($urandom);
            step();
            chk("idle_en", bus_enable, 1'b0);
            chk("idle_bus", unsync_bus, exp_bus);
            chk("idle_ready", in_ready, 1'b1);
            chk("idle_done", tx_done, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        ack_async = 1'b0;
        exp_bus   = '0;
        #1;
        chk("rst_bus", unsync_bus, 8'h00);
        chk("rst_en", bus_enable, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_err", tx_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single transfer, then back-to-back with the next word held valid.
        accept(8'hC1);
        handshake(3, 3);
        accept(8'hC0);
        handshake(2, 1);
        idle(3);

        // Randomized transfers: random words, ack delays and gaps.
        for (int i = 0; i < 16; i++) begin
            accept(BW'($urandom));
            handshake(int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
        end

        // Destination never acknowledges.
        idle(1);
        accept(8'h5A);
        in_valid = 1'b0;
`ifdef DATA_SYNC_TX_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("to_pre_err", tx_err, 1'b0);
        chk("to_pre_en", bus_enable, 1'b1);
        step();
        chk("to_err", tx_err, 1'b1);
        chk("to_en", bus_enable, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_bus", unsync_bus, exp_bus);
        chk("to_done", tx_done, 1'b0);
        step();
        chk("to_err_pulse_end", tx_err, 1'b0);
`else
        repeat (100) begin
            step();
            chk("stall_en", bus_enable, 1'b1);
            chk("stall_err", tx_err, 1'b0);
        end
        handshake(0, 2);
`endif
        idle(2);

        // Asynchronous reset in the middle of REQ.
        accept(8'hC1);
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_bus = '0;
        chk("mid_rst_bus", unsync_bus, 8'h00);
        chk("mid_rst_en", bus_enable, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        accept(8'h3C);
        handshake(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
